ex_mem_stage: RTL
=================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 rst  in  1  reset rst, synchronous, active-low.
REQ-003 flush  in  1  kill all buffered entries (exception/branch redirect).
REQ-004 ex_valid  in  1  execute stage offers an entry.
REQ-005 ex_ready  out  1  stage can accept an entry; driven from a flop only.
REQ-006 ex_pc  in  32  PC of the offered instruction.
REQ-007 ex_alu_result  in  32  ALU result, used as data or memory address.
REQ-008 ex_alu_overflow  in  1  ALU signed overflow (trapping add/sub only).
REQ-009 ex_wreg_en / ex_waddr  in  1/5  register write-back enable and target.
REQ-010 ex_mem_ren / ex_mem_wen  in  1/1  load / store request.
REQ-011 ex_mem_size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as word).
REQ-012 ex_store_data  in  32  unaligned store source (rt).
REQ-013 mem_valid  out  1  head entry valid toward memory stage.
REQ-014 mem_ready  in  1  memory stage accepts head entry.
REQ-015 mem_pc, mem_result, mem_addr  out  32 each  head PC, ALU result, address (mem_addr = mem_result).
REQ-016 mem_wreg_en / mem_waddr  out  1/5  write-back control, exception-suppressed.
REQ-017 mem_ren / mem_wen / mem_byte_en  out  1/1/4  exception-suppressed memory request, lane enables.
REQ-018 mem_store_data  out  32  lane-replicated store data.
REQ-019 mem_exc / mem_exc_code / mem_badvaddr  out  1/5/32  exception flag, MIPS ExcCode, faulting address.

Function
REQ-020 Two-entry skid buffer: main (drives mem_*) and skid; states EMPTY, ONE, TWO.
REQ-021 Transfer in = ex_valid & ex_ready; transfer out = mem_valid & mem_ready; mem_valid = state != EMPTY.
REQ-022 ex_ready SHALL be 1 in EMPTY and ONE, 0 in TWO, registered.
REQ-023 EMPTY: in -> ONE (entry to main).
REQ-024 ONE: in&out -> ONE (new entry to main); in only -> TWO (new entry to skid); out only -> EMPTY.
REQ-025 TWO: out -> ONE (skid moves to main, same edge); no out -> TWO, all held.
REQ-026 Latency: entry accepted at edge N appears on mem_* after edge N when buffer was EMPTY or draining; zero bubbles at full throughput.
REQ-027 mem_* SHALL be stable while mem_valid & ~mem_ready.
REQ-028 Decode is performed at capture; stored entries hold decoded byte_en, store_data, exception fields.
REQ-029 Byte: byte_en = 4'b0001 << addr[1:0], store_data = {4{d[7:0]}}; half: byte_en = 4'b0011 << {addr[1],0}, store_data = {2{d[15:0]}}; word/reserved: 4'b1111, d.
REQ-030 Exception priority: overflow (code 12) > AdEL (code 4, load) > AdES (code 5, store).
REQ-031 Misaligned: half with addr[0]=1, word with addr[1:0]!=0.
REQ-032 When exc set: wreg_en, ren, wen forced 0; badvaddr = addr for AdEL/AdES, 0 for overflow.
REQ-033 flush SHALL take priority over all transfers: next state EMPTY, ex input ignored that cycle.
REQ-034 mem_exc_code and mem_badvaddr are 0 when mem_exc = 0.

Reset
REQ-035 rst low at an edge: state EMPTY, mem_valid 0, ex_ready 1, all mem_* outputs 0, mid-stream entries discarded.
REQ-036 No transfer in or out is counted on a reset edge.

Configuration
REQ-037 EX_MEM_ALIGN_CHECK_EN defined: AdEL/AdES detection per REQ-030..032.
REQ-038 Undefined: no address-error exceptions; byte_en/store_data per REQ-029 using addr bits regardless; overflow still reported.

Structure
REQ-039 Shared package holds ExcCode constants (EXC_OV=12, EXC_ADEL=4, EXC_ADES=5), size encodings, entry struct.
REQ-040 One sub-module, ex_mem_decode: combinational lane/exception decode, instantiated once at the input.

Verification
REQ-041 Load word addr 0x1000_0004, mem_ready=1 -> next cycle mem_valid=1, byte_en=1111, ren=1, exc=0.
REQ-042 Store byte d=0x0000_00AB addr 0x...3 -> byte_en=1000, store_data=0xABABABAB.
REQ-043 Load half addr 0x1000_0001 (macro on) -> exc=1, code=4, badvaddr=0x1000_0001, ren=0, wreg_en=0; macro off -> exc=0, byte_en=0110... no: byte_en=0011, ren=1.
REQ-044 ADDE with overflow=1, wreg_en=1 -> exc=1, code=12, wreg_en=0.
REQ-045 mem_ready=0 for 3 cycles with ex_valid=1 -> ex_ready drops after 2 accepts, mem_* stable; release -> both entries delivered in order, none lost/duplicated.
REQ-046 flush or rst low while TWO -> next cycle mem_valid=0, ex_ready=1.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// Shared definitions for the EX/MEM pipeline boundary: exception codes,
// access-size encodings, buffer states and the decoded entry record.
// Optional feature macro: EX_MEM_ALIGN_CHECK_EN (address-error detection).
package ex_mem_pkg;

    // MIPS ExcCode values reported on mem_exc_code
    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_OV   = 5'd12;

`ifdef EX_MEM_ALIGN_CHECK_EN
    localparam logic ALIGN_CHECK_EN = 1'b1;
`else
    localparam logic ALIGN_CHECK_EN = 1'b0;
`endif

    // Memory access size; the reserved code behaves as a word access
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_RSVD = 2'd3
    } mem_size_e;

    // Skid-buffer occupancy
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_e;

    // Fully decoded entry as held in the main and skid slots
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] result;
        logic        wreg_en;
        logic [4:0]  waddr;
        logic        ren;
        logic        wen;
        logic [3:0]  byte_en;
        logic [31:0] store_data;
        logic        exc;
        logic [4:0]  exc_code;
        logic [31:0] badvaddr;
    } ex_mem_entry_t;

    // True when the access is not naturally aligned for its size
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = addr_lo[0];
            default:   mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ex_mem_decode.sv
// Combinational decode of one execute-stage offer into a stored entry:
// byte-lane enables, lane-replicated store data and exception fields.
// Address-error detection is active only with EX_MEM_ALIGN_CHECK_EN.
module ex_mem_decode
    import ex_mem_pkg::*;
(
    input  logic [31:0]   pc,
    input  logic [31:0]   alu_result,
    input  logic          alu_overflow,
    input  logic          wreg_en,
    input  logic [4:0]    waddr,
    input  logic          mem_ren,
    input  logic          mem_wen,
    input  logic [1:0]    mem_size,
    input  logic [31:0]   store_data,
    output ex_mem_entry_t entry
);

    logic       misalign_s;
    logic       adel_s;
    logic       ades_s;
    logic [3:0] byte_en_s;
    logic [31:0] sdata_s;

    // Lane enables and replicated store data from size and low address bits
    always_comb begin
        byte_en_s = 4'b1111;
        sdata_s   = store_data;
        case (mem_size)
            SIZE_BYTE: begin
                byte_en_s = 4'b0001 << alu_result[1:0];
                sdata_s   = {4{store_data[7:0]}};
            end
            SIZE_HALF: begin
                byte_en_s = 4'b0011 << {alu_result[1], 1'b0};
                sdata_s   = {2{store_data[15:0]}};
            end
            default: begin
                byte_en_s = 4'b1111;
                sdata_s   = store_data;
            end
        endcase
    end

    // Exception detection with overflow > AdEL > AdES priority, request suppression
    always_comb begin
        misalign_s = is_misaligned(mem_size, alu_result[1:0]);
        adel_s     = ALIGN_CHECK_EN & mem_ren & misalign_s;
        ades_s     = ALIGN_CHECK_EN & mem_wen & misalign_s;

        entry            = '0;
        entry.pc         = pc;
        entry.result     = alu_result;
        entry.waddr      = waddr;
        entry.byte_en    = byte_en_s;
        entry.store_data = sdata_s;

        if (alu_overflow) begin
            entry.exc      = 1'b1;
            entry.exc_code = EXC_OV;
            entry.badvaddr = 32'h0000_0000;
        end else if (adel_s) begin
            entry.exc      = 1'b1;
            entry.exc_code = EXC_ADEL;
            entry.badvaddr = alu_result;
        end else if (ades_s) begin
            entry.exc      = 1'b1;
            entry.exc_code = EXC_ADES;
            entry.badvaddr = alu_result;
        end else begin
            entry.exc      = 1'b0;
            entry.exc_code = EXC_NONE;
            entry.badvaddr = 32'h0000_0000;
        end

        entry.wreg_en = wreg_en & ~entry.exc;
        entry.ren     = mem_ren & ~entry.exc;
        entry.wen     = mem_wen & ~entry.exc;
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register built as a two-entry skid buffer (main + skid).
// Entries are decoded on capture; mem_* is driven straight from the main slot.
// ex_ready comes from a flop so the upstream stage sees no combinational path.
// Optional feature macro: EX_MEM_ALIGN_CHECK_EN (address-error exceptions).
module ex_mem_stage
    import ex_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_alu_result,
    input  logic        ex_alu_overflow,
    input  logic        ex_wreg_en,
    input  logic [4:0]  ex_waddr,
    input  logic        ex_mem_ren,
    input  logic        ex_mem_wen,
    input  logic [1:0]  ex_mem_size,
    input  logic [31:0] ex_store_data,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_pc,
    output logic [31:0] mem_result,
    output logic [31:0] mem_addr,
    output logic        mem_wreg_en,
    output logic [4:0]  mem_waddr,
    output logic        mem_ren,
    output logic        mem_wen,
    output logic [3:0]  mem_byte_en,
    output logic [31:0] mem_store_data,
    output logic        mem_exc,
    output logic [4:0]  mem_exc_code,
    output logic [31:0] mem_badvaddr
);

    buf_state_e    state_r;
    buf_state_e    state_next_s;
    logic          ex_ready_r;
    ex_mem_entry_t main_r;
    ex_mem_entry_t skid_r;
    ex_mem_entry_t dec_entry_s;

    logic xfer_in_s;
    logic xfer_out_s;
    logic mem_valid_s;
    logic main_ld_dec_s;
    logic main_ld_skid_s;
    logic skid_ld_s;

    ex_mem_decode u_decode (
        .pc           (ex_pc),
        .alu_result   (ex_alu_result),
        .alu_overflow (ex_alu_overflow),
        .wreg_en      (ex_wreg_en),
        .waddr        (ex_waddr),
        .mem_ren      (ex_mem_ren),
        .mem_wen      (ex_mem_wen),
        .mem_size     (ex_mem_size),
        .store_data   (ex_store_data),
        .entry        (dec_entry_s)
    );

    assign xfer_in_s  = ex_valid & ex_ready_r;
    assign xfer_out_s = mem_valid_s & mem_ready;

    // State register and registered ready; ready is low exactly when both slots fill
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_EMPTY;
            ex_ready_r <= 1'b1;
        end else begin
            state_r    <= state_next_s;
            ex_ready_r <= (state_next_s != ST_TWO);
        end
    end

    // Next-state and slot-load selection; flush overrides every transfer
    always_comb begin
        state_next_s   = state_r;
        main_ld_dec_s  = 1'b0;
        main_ld_skid_s = 1'b0;
        skid_ld_s      = 1'b0;
        if (flush) begin
            state_next_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (xfer_in_s) begin
                        state_next_s  = ST_ONE;
                        main_ld_dec_s = 1'b1;
                    end else begin
                        state_next_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (xfer_in_s && xfer_out_s) begin
                        state_next_s  = ST_ONE;
                        main_ld_dec_s = 1'b1;
                    end else if (xfer_in_s) begin
                        state_next_s = ST_TWO;
                        skid_ld_s    = 1'b1;
                    end else if (xfer_out_s) begin
                        state_next_s = ST_EMPTY;
                    end else begin
                        state_next_s = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (xfer_out_s) begin
                        state_next_s   = ST_ONE;
                        main_ld_skid_s = 1'b1;
                    end else begin
                        state_next_s = ST_TWO;
                    end
                end
                default: begin
                    state_next_s = ST_EMPTY;
                end
            endcase
        end
    end

    // Entry storage; reset and flush clear the main slot so outputs read zero
    always_ff @(posedge clk) begin
        if (!rst) begin
            main_r <= '0;
            skid_r <= '0;
        end else if (flush) begin
            main_r <= '0;
            skid_r <= '0;
        end else begin
            if (main_ld_dec_s) begin
                main_r <= dec_entry_s;
            end else if (main_ld_skid_s) begin
                main_r <= skid_r;
            end else begin
                main_r <= main_r;
            end
            if (skid_ld_s) begin
                skid_r <= dec_entry_s;
            end else begin
                skid_r <= skid_r;
            end
        end
    end

    // Output decode: valid whenever the buffer holds at least one entry
    always_comb begin
        mem_valid_s = (state_r != ST_EMPTY);
    end

    assign ex_ready       = ex_ready_r;
    assign mem_valid      = mem_valid_s;
    assign mem_pc         = main_r.pc;
    assign mem_result     = main_r.result;
    assign mem_addr       = main_r.result;
    assign mem_wreg_en    = main_r.wreg_en;
    assign mem_waddr      = main_r.waddr;
    assign mem_ren        = main_r.ren;
    assign mem_wen        = main_r.wen;
    assign mem_byte_en    = main_r.byte_en;
    assign mem_store_data = main_r.store_data;
    assign mem_exc        = main_r.exc;
    assign mem_exc_code   = main_r.exc_code;
    assign mem_badvaddr   = main_r.badvaddr;

endmodule
